// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, plus the scoreboard's default depth and busy-mask type.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [7:0]  lc3b_regmask;

    // One pending write per pipeline stage between decode and write-back.
    localparam int SB_MAX_INFLIGHT = 3;

endpackage

// File: rtl/sb_counter.sv
// One register's pending-writer counter: +inc, -dec_a, -dec_b, clear wins,
// clamps at 0 (flagging underflow) and saturates at MAX.
module sb_counter #(
    parameter int MAX   = 3,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             dec_a_i,
    input  logic             dec_b_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             underflow_o
);

    localparam int W1 = CNT_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [W1-1:0]    up, down, diff;

    always_comb begin
        up          = {1'b0, count_q} + W1'(inc_i);
        down        = W1'(dec_a_i) + W1'(dec_b_i);
        diff        = up - down;
        underflow_o = 1'b0;
        count_d     = diff[CNT_W-1:0];
        if (clr_i) begin
            count_d = '0;
        end else if (up < down) begin
            count_d     = '0;
            underflow_o = 1'b1;
        end else if (diff > W1'(MAX)) begin
            count_d = CNT_W'(MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counts drive the stall.
// Optional SCOREBOARD_WB_BYPASS_EN lets a source issue in its producer's write-back cycle.
module regfile_scoreboard
    import lc3b_types::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  lc3b_reg     id_sr1,
    input  lc3b_reg     id_sr2,
    input  logic        id_sr1_used,
    input  logic        id_sr2_used,
    input  lc3b_reg     id_dest,
    input  logic        id_dest_used,
    output logic        id_stall,
    output logic        id_issue,
    input  logic        wb_valid,
    input  lc3b_reg     wb_dest,
    input  logic        squash_valid,
    input  lc3b_reg     squash_dest,
    input  logic        flush_all,
    output lc3b_regmask busy_mask,
    output logic        sb_err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] cnt [8];
    logic [7:0]       uflow;
    logic             sr1_haz, sr2_haz, dest_full;
    lc3b_regmask      busy_mask_q, busy_mask_d;
    logic             sb_err_q, sb_err_d;

    always_comb begin
        sr1_haz   = cnt[id_sr1] != '0;
        sr2_haz   = cnt[id_sr2] != '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Last pending writer retiring now: regfile write-through supplies the value.
        if (wb_valid && wb_dest == id_sr1 && cnt[id_sr1] == CNT_W'(1)) sr1_haz = 1'b0;
        if (wb_valid && wb_dest == id_sr2 && cnt[id_sr2] == CNT_W'(1)) sr2_haz = 1'b0;
`endif
        dest_full = cnt[id_dest] == CNT_W'(MAX_INFLIGHT);
    end

    assign id_stall = id_valid & ((sr1_haz & id_sr1_used) | (sr2_haz & id_sr2_used) |
                                  (dest_full & id_dest_used));
    assign id_issue = id_valid & ~id_stall;

    generate
        for (genvar r = 0; r < 8; r++) begin : g_cnt
            sb_counter #(.MAX(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
                .clk_i       (clk),
                .reset_i     (reset),
                .inc_i       (id_issue & id_dest_used & (id_dest == lc3b_reg'(r))),
                .dec_a_i     (wb_valid & (wb_dest == lc3b_reg'(r))),
                .dec_b_i     (squash_valid & (squash_dest == lc3b_reg'(r))),
                .clr_i       (flush_all),
                .count_o     (cnt[r]),
                .underflow_o (uflow[r])
            );
            assign busy_mask_d[r] = cnt[r] != '0;
        end
    endgenerate

    assign sb_err_d = sb_err_q | (|uflow);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            busy_mask_q <= busy_mask_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign busy_mask = busy_mask_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a count-array reference model.
module tb_regfile_scoreboard;
    import lc3b_types::*;

    logic clk = 1'b0, reset = 1'b1;
    logic id_valid = 0, id_sr1_used = 0, id_sr2_used = 0, id_dest_used = 0;
    lc3b_reg id_sr1 = 0, id_sr2 = 0, id_dest = 0, wb_dest = 0, squash_dest = 0;
    logic wb_valid = 0, squash_valid = 0, flush_all = 0;
    logic id_stall, id_issue, sb_err;
    lc3b_regmask busy_mask;

    int checks = 0, errors = 0;
    int cnt [8];
    bit [7:0] exp_busy = 0;
    bit exp_err = 0, started = 0;

    regfile_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used), .id_dest(id_dest),
        .id_dest_used(id_dest_used), .id_stall(id_stall), .id_issue(id_issue),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .squash_valid(squash_valid),
        .squash_dest(squash_dest), .flush_all(flush_all), .busy_mask(busy_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit src_haz(int s);
        bit h = cnt[s] != 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (cnt[s] == 1 && wb_valid && int'(wb_dest) == s) h = 0;
`endif
        return h;
    endfunction

    function automatic bit model_stall();
        return id_valid && ((id_sr1_used && src_haz(int'(id_sr1))) ||
                            (id_sr2_used && src_haz(int'(id_sr2))) ||
                            (id_dest_used && cnt[id_dest] == 3));
    endfunction

    // Reference model: counts of pending writers, advanced on each rising edge.
    always @(posedge clk) begin
        bit iss;
        iss = id_valid && !model_stall();
        started = 1;
        if (reset) begin
            foreach (cnt[r]) cnt[r] = 0;
            exp_busy = 0;
            exp_err  = 0;
        end else begin
            for (int r = 0; r < 8; r++) exp_busy[r] = cnt[r] != 0;
            for (int r = 0; r < 8; r++) begin
                int n;
                n = cnt[r] + int'(iss && id_dest_used && int'(id_dest) == r)
                           - int'(wb_valid && int'(wb_dest) == r)
                           - int'(squash_valid && int'(squash_dest) == r);
                if (flush_all) n = 0;
                else if (n < 0) begin n = 0; exp_err = 1; end
                cnt[r] = n;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("id_stall", id_stall, model_stall());
            chk("id_issue", id_issue, id_valid && !model_stall());
            chk("busy_mask", busy_mask, exp_busy);
            chk("sb_err", sb_err, exp_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_sr1_used = 0; id_sr2_used = 0; id_dest_used = 0;
        wb_valid = 0; squash_valid = 0; flush_all = 0;
    endtask

    task automatic issue(input int d);
        id_valid = 1; id_sr1_used = 0; id_sr2_used = 0; id_dest_used = 1; id_dest = lc3b_reg'(d);
    endtask

    initial begin
        foreach (cnt[r]) cnt[r] = 0;
        step(); step();
        reset = 0;
        #1;
        chk("reset busy", busy_mask, 0);
        chk("reset err", sb_err, 0);
        chk("reset stall", id_stall, 0);

        // RAW on R1
        issue(1);
        #1 chk("R1 issue", id_issue, 1);
        step();
        issue(2); id_sr1 = 1; id_sr1_used = 1;
        #1 chk("raw stall", id_stall, 1);
        step(); step();
        wb_valid = 1; wb_dest = 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("raw wb cycle", id_stall, 0);
        step();
`else
        #1 chk("raw wb cycle", id_stall, 1);
        step();
        wb_valid = 0;
        #1 chk("raw release", id_stall, 0);
        step();
`endif
        idle();
        wb_valid = 1; wb_dest = 2;
        step();
        idle();

        // Saturate R3
        issue(3); step(); step(); step();
        #1 chk("R3 full stall", id_stall, 1);
        wb_valid = 1; wb_dest = 3;
        #1 chk("R3 wb same cycle", id_stall, 1);
        step();
        wb_valid = 0;
        #1 chk("R3 release", id_stall, 0);
        step();
        idle();
        chk("model cnt3", cnt[3], 3);
        step();
        chk("busy R3", busy_mask, 8'h08);
        wb_valid = 1; wb_dest = 3;
        step(); step(); step();
        idle();

        // Squash R4 and retire R5 together
        issue(4); step();
        issue(5); step();
        idle();
        squash_valid = 1; squash_dest = 4; wb_valid = 1; wb_dest = 5;
        step();
        idle(); step();
        chk("sq/wb busy", busy_mask, 0);
        chk("sq/wb err", sb_err, 0);

        // Two decrements of one register in a cycle
        issue(2); step(); step();
        idle();
        squash_valid = 1; squash_dest = 2; wb_valid = 1; wb_dest = 2;
        step();
        idle();
        chk("model cnt2", cnt[2], 0);
        chk("double dec err", sb_err, 0);

        // Flush beats a concurrent issue
        issue(6); step();
        flush_all = 1;
        #1 chk("flush issue", id_issue, 1);
        step();
        idle();
        chk("model cnt6", cnt[6], 0);
        step();
        chk("flush busy", busy_mask, 0);

        // Underflow on R0
        wb_valid = 1; wb_dest = 0;
        step();
        idle();
        chk("uflow err", sb_err, 1);
        chk("model cnt0", cnt[0], 0);
        step(); step();
        chk("uflow sticky", sb_err, 1);

        // Reset mid-operation
        issue(1); step();
        idle(); reset = 1;
        step();
        reset = 0;
        chk("mid reset err", sb_err, 0);
        chk("mid reset busy", busy_mask, 0);
        id_valid = 1; id_sr1 = 1; id_sr1_used = 1; id_dest = 2; id_dest_used = 1;
        #1 chk("post reset no hazard", id_stall, 0);
        step();
        idle();
        wb_valid = 1; wb_dest = 2;
        step();
        idle(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

In-order issue controller for the decode stage's register file. Tracks, per architectural register, how many issued-but-unretired instructions will write it, and stalls decode when a source or destination operand is still pending. Sits beside the decode datapath: it consumes decode's operand selects and `load_regfile` intent, and the write-back stage's commit and squash events, and produces the decode stall/issue handshake.

## Interface
Parameters:
- MAX_INFLIGHT, 3, maximum pending writes to one register; one per stage between decode and write-back.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- id_valid  in  1  decode holds a valid instruction.
- id_sr1, id_sr2  in  lc3b_reg  source register numbers, after store-mux selection.
- id_sr1_used, id_sr2_used  in  1  source is actually read.
- id_dest  in  lc3b_reg  destination, after dest-mux (R7 for JSR/TRAP).
- id_dest_used  in  1  instruction will assert `load_regfile` at write-back.
- id_stall  out  1  hold decode; combinational.
- id_issue  out  1  instruction leaves decode this cycle; `id_valid & ~id_stall`.
- wb_valid  in  1  write-back commits a register write (`load_regfile`).
- wb_dest  in  lc3b_reg  committed register.
- squash_valid  in  1  an in-flight writer is killed (branch flush).
- squash_dest  in  lc3b_reg  destination of the killed writer.
- flush_all  in  1  discard all pending state.
- busy_mask  out  8  bit r set when count[r] != 0; registered.
- sb_err  out  1  sticky; decrement of a zero counter.

## Operation
- State: eight counters count[0..7], width CNT_W = $clog2(MAX_INFLIGHT+1); plus sb_err.
- Hazard for register r = count[r] != 0.
- id_stall = id_valid & (sr1 hazard & sr1_used | sr2 hazard & sr2_used | dest_used & count[dest]==MAX_INFLIGHT).
- WAW with count below MAX_INFLIGHT does not stall; in-order retire ordering is relied upon.
- Per-register next value = count + inc − dec_wb − dec_sq. inc = id_issue & id_dest_used & id_dest==r. dec_wb and dec_sq are evaluated independently, so two decrements of one register in a cycle are legal.
- Simultaneous inc and dec to the same register: net count unchanged.
- Underflow: result clamps at 0 and sb_err sets. sb_err clears only on reset.
- flush_all: all counters go to 0 next cycle. It takes priority over every inc and dec in the same cycle, including id_issue.
- Reset, including mid-operation: counters 0, busy_mask 0, sb_err 0. id_stall is 0 while reset is held unless id_valid with a pending hazard, and there are no hazards after reset.

## Timing
- Issue, retire, squash and flush take effect on count at the next rising edge; busy_mask follows one cycle after.
- id_stall/id_issue are combinational from current count and decode inputs; zero-cycle response.
- A dependent instruction stalls at least until the cycle after the producer's wb_valid (without bypass).
- Decode must hold all id_* inputs stable while id_stall=1.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined:
  - A source hazard on r is ignored when count[r]==1 and wb_valid & wb_dest==r in the same cycle.
  - This relies on the regfile's write-through.
  - A squash in the same cycle does not cancel the bypass.
- Undefined: the source stalls one extra cycle, until count reaches 0.

## Structure
- lc3b_types already provides lc3b_reg and lc3b_word.
- Add to lc3b_types:
  - SB_MAX_INFLIGHT constant (default for MAX_INFLIGHT).
  - lc3b_regmask typedef (logic [7:0]) for busy_mask.
- One sub-module, `sb_counter`: a single saturating up/down counter with inc, two decrements, clear, and an underflow flag. Instantiated eight times via generate.

## Test plan
- Reset with id_valid=0 → busy_mask=0, sb_err=0, id_stall=0.
- Issue ADD R1 (dest_used); next cycle ADD R2←R1 → id_stall=1 until count[1]=0.
  - Without the macro, release one cycle after wb_valid(R1).
  - With the macro, release in the wb_valid(R1) cycle.
- Issue three writers to R3 (MAX_INFLIGHT=3); a fourth writer to R3 → id_stall=1. A wb_valid(R3) the same cycle does not release it; the next cycle releases it with net count 3.
- In-flight writers to R4 and R5; squash_valid(R4) with wb_valid(R5) in the same cycle → busy_mask=0 next cycle, sb_err=0.
- In-flight writer to R6; flush_all asserted in a cycle where a writer to R6 also issues → count[6]=0, busy_mask=0 next cycle.
- wb_valid(R0) with count[0]=0 → sb_err=1 and stays 1 until reset; count[0] stays 0.
